banked_data_mem: RTL and testbench
==================================

# banked_data_mem

Two-port, bank-interleaved, byte-writable data memory for the RI5CY core subsystem. It is a parametrised successor to the single-port data BRAM wrapper.
- Port 0 serves the core LSU; port 1 serves a loader/debug master.
- Both ports use the core's req/gnt/rvalid data protocol.
- Requests to different banks in the same cycle are served concurrently.
- Same-bank conflicts are arbitrated with port-0 priority and bounded starvation of port 1.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width per port
- NUM_BANKS, 4, number of word-wide banks; power of two, ≥2
- BANK_DEPTH, 256, words per bank; power of two
- READ_LATENCY, 1, cycles from grant to rvalid; legal values 1 or 2
- MAX_WAIT, 3, denied cycles port 1 tolerates before it takes priority; ≥1

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  [1:0]  request per port (bit 0 = core, bit 1 = loader)
- gnt_o  out  [1:0]  grant per port, combinational from the current request
- addr_i  in  [2*ADDR_WIDTH-1:0]  byte address; port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- we_i  in  [1:0]  1 = write, 0 = read
- be_i  in  [7:0]  byte enables; 4 bits per port
- wdata_i  in  [63:0]  write data; 32 bits per port
- rvalid_o  out  [1:0]  response valid, one pulse per granted request (reads and writes)
- rdata_o  out  [63:0]  read data; valid only with rvalid
- err_o  out  [1:0]  error flag, qualified by rvalid

## Operation
Address mapping:
- Word address `w = addr[ADDR_WIDTH-1:2]`.
- Bank = `w[log2(NUM_BANKS)-1:0]` (low-order interleave).
- Row = `w >> log2(NUM_BANKS)`, taken modulo BANK_DEPTH.
- `addr[1:0]` is ignored.

Access behaviour:
- Write: only bytes whose `be` bit is set are written. `be = 0000` is legal and leaves memory unchanged.
- Read: returns the full 32-bit word; `be` is ignored.

Arbitration, evaluated each cycle:
- A lone request is always granted.
- Two requests to different banks are both granted.
- Two requests to the same bank: port 0 wins, except when `wait_cnt == MAX_WAIT`, in which case port 1 wins.
- A denied port keeps `req` and its attributes stable until granted.

Starvation counter `wait_cnt`:
- Width `$clog2(MAX_WAIT+1)`.
- Increments when port 1 requests and is denied.
- Clears when port 1 is granted.
- Saturates at MAX_WAIT.

Response pipeline:
- Per port, a READ_LATENCY-deep shift of {valid, err}.
- Responses return in grant order; the fixed latency makes each port in-order.
- No backpressure on responses.

Memory contents are not reset.

## Timing
- Grant in cycle N produces rvalid in cycle N+READ_LATENCY.
- With READ_LATENCY=2, rdata is held in an output register.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later, on either port.
- Full throughput: one grant per port per cycle when there is no conflict.

Reset:
- While `rst_i` is high, gnt_o, rvalid_o, err_o are all 0, and rdata_o is 0.
- Reset asserted mid-operation discards in-flight responses: no rvalid appears after reset for requests granted before it.
- Reset also clears `wait_cnt`.
- The first grant is possible in the cycle after `rst_i` deasserts.

## Configuration
- Macro `BANKED_DATA_MEM_ERR_EN`:
  - Defined: a request with `w >= NUM_BANKS*BANK_DEPTH` is granted immediately, never conflicts, never touches a bank, and returns rvalid at normal latency with err=1 and rdata=0. All other requests return err=0.
  - Undefined: the range check is absent; rows wrap modulo BANK_DEPTH and err_o is tied 0.

## Test plan
- **Reset then single-port traffic.** Hold rst_i high, then release. Port 0 writes `0xDEADBEEF` to 0x10 with be=1111, then reads 0x10. Required: gnt same cycle, rvalid after READ_LATENCY, rdata=0xDEADBEEF, err=0.
- **Byte enables.** Write 0x11223344 to 0x20, then 0xAABBCCDD with be=0101. Required: read returns 0x11BB33DD.
- **Concurrent different banks.** With NUM_BANKS=4, port 0 reads 0x00 (bank 0) while port 1 writes 0x04 (bank 1). Required: both gnt=1 in the same cycle, both rvalid in the same later cycle.
- **Same-bank starvation.** Port 0 and port 1 continuously request address 0x00 with MAX_WAIT=3. Required: port 1 denied for 3 cycles and granted in the 4th; port 0 denied in that cycle; pattern repeats every 4 cycles.
- **Out-of-range access (macro defined).** Read byte address 4*NUM_BANKS*BANK_DEPTH. Required: gnt=1, rvalid with err=1, rdata=0. Without the macro: returns row-0 data, err=0.
- **Reset mid-flight.** Assert rst_i in the cycle after a grant, with READ_LATENCY=2. Required: no rvalid appears afterwards, and wait_cnt=0.

Source files
------------

// File: rtl/banked_data_mem.sv
// Two-port, bank-interleaved, byte-writable data memory with port-0 priority and bounded port-1 starvation.
// Define BANKED_DATA_MEM_ERR_EN to flag out-of-range word addresses with err_o instead of wrapping rows.
module banked_data_mem #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_DEPTH   = 256,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    output logic [1:0]              gnt_o,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]              we_i,
    input  logic [7:0]              be_i,
    input  logic [63:0]             wdata_i,
    output logic [1:0]              rvalid_o,
    output logic [63:0]             rdata_o,
    output logic [1:0]              err_o
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WORD_W-1:0] word [2];
    logic [BANK_W-1:0] bank [2];
    logic [ROW_W-1:0]  row  [2];
    logic [1:0]        oor;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            word[p] = addr_i[p*ADDR_WIDTH+2 +: WORD_W];
            bank[p] = word[p][BANK_W-1:0];
            row[p]  = word[p][BANK_W +: ROW_W];
        end
    end

`ifdef BANKED_DATA_MEM_ERR_EN
    localparam logic [WORD_W:0] TOTAL_WORDS = (WORD_W+1)'(NUM_BANKS * BANK_DEPTH);
    assign oor[0] = {1'b0, word[0]} >= TOTAL_WORDS;
    assign oor[1] = {1'b0, word[1]} >= TOTAL_WORDS;
`else
    assign oor = 2'b00;
`endif

    // Byte offset and any address bits above the row index carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    // Arbitration: same-bank clash goes to port 0 unless port 1 has waited MAX_WAIT cycles.
    logic [WAIT_W-1:0] wait_cnt;
    logic              clash;
    logic              p1_first;

    assign clash    = req_i[0] & req_i[1] & ~|oor & (bank[0] == bank[1]);
    assign p1_first = (wait_cnt == WAIT_MAX);
    assign gnt_o[0] = ~rst_i & req_i[0] & ~(clash & p1_first);
    assign gnt_o[1] = ~rst_i & req_i[1] & ~(clash & ~p1_first);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (gnt_o[1]) begin
            wait_cnt <= '0;
        end else if (req_i[1] && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Stage p0 -> p1: bank arrays, each driven by at most one granted in-range port.
    logic [1:0]              access;
    logic [32*NUM_BANKS-1:0] bank_rdata;

    assign access = gnt_o & ~oor;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0]      ram [BANK_DEPTH];
        logic [31:0]      q;
        logic             sel0;
        logic             sel1;
        logic [ROW_W-1:0] row_b;
        logic             we_b;
        logic [3:0]       be_b;
        logic [31:0]      wd_b;

        assign sel0  = access[0] && (bank[0] == BANK_W'(b));
        assign sel1  = access[1] && (bank[1] == BANK_W'(b));
        assign row_b = sel0 ? row[0]        : row[1];
        assign we_b  = sel0 ? we_i[0]       : we_i[1];
        assign be_b  = sel0 ? be_i[3:0]     : be_i[7:4];
        assign wd_b  = sel0 ? wdata_i[31:0] : wdata_i[63:32];

        always_ff @(posedge clk_i) begin
            if (sel0 || sel1) begin
                if (we_b) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_b[i]) ram[row_b][8*i +: 8] <= wd_b[8*i +: 8];
                    end
                end
                q <= ram[row_b];
            end
        end

        assign bank_rdata[32*b +: 32] = q;
    end

    logic [1:0]        vld_p1;
    logic [1:0]        err_p1;
    logic [BANK_W-1:0] bank_p1 [2];
    logic [63:0]       rdata_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_p1 <= 2'b00;
        else       vld_p1 <= gnt_o;
    end

    always_ff @(posedge clk_i) begin
        err_p1     <= oor;
        bank_p1[0] <= bank[0];
        bank_p1[1] <= bank[1];
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_p1[32*p +: 32] = err_p1[p] ? 32'h0 : bank_rdata[32*int'(bank_p1[p]) +: 32];
        end
    end

    logic [1:0]  out_vld;
    logic [1:0]  out_err;
    logic [63:0] out_data;

    if (READ_LATENCY == 2) begin : g_lat2
        // Stage p1 -> p2: registered read data.
        logic [1:0]  vld_p2;
        logic [1:0]  err_p2;
        logic [63:0] rdata_p2;

        always_ff @(posedge clk_i) begin
            if (rst_i) vld_p2 <= 2'b00;
            else       vld_p2 <= vld_p1;
        end

        always_ff @(posedge clk_i) begin
            err_p2   <= err_p1;
            rdata_p2 <= rdata_p1;
        end

        assign out_vld  = vld_p2;
        assign out_err  = err_p2;
        assign out_data = rdata_p2;
    end else begin : g_lat1
        assign out_vld  = vld_p1;
        assign out_err  = err_p1;
        assign out_data = rdata_p1;
    end

    // Outputs stay quiet during reset even while the pipeline registers clear.
    always_comb begin
        rvalid_o = out_vld & ~{2{rst_i}};
        err_o    = rvalid_o & out_err;
        for (int p = 0; p < 2; p++) begin
            rdata_o[32*p +: 32] = rvalid_o[p] ? out_data[32*p +: 32] : 32'h0;
        end
    end

endmodule

// File: tb/tb_banked_data_mem.sv
// Randomized bench for banked_data_mem against a word-array / response-queue reference model.
`timescale 1ns/1ps
module tb_banked_data_mem;

    localparam int AW    = 32;
    localparam int NB    = 4;
    localparam int BD    = 16;
    localparam int RL    = 2;
    localparam int MW    = 3;
    localparam int TOTAL = NB * BD;
`ifdef BANKED_DATA_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, gnt, we, rvalid, err;
    logic [2*AW-1:0] addr;
    logic [7:0]    be;
    logic [63:0]   wdata, rdata;

    banked_data_mem #(
        .ADDR_WIDTH(AW), .NUM_BANKS(NB), .BANK_DEPTH(BD),
        .READ_LATENCY(RL), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          rd;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          wc    = 0;
    logic [31:0] mm [TOTAL];
    rsp_t        q0[$];
    rsp_t        q1[$];
    bit [1:0]    last_g = 2'b00;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] ad,
                            input logic [3:0] bb, input logic [31:0] dd);
        req[p]           = r;
        we[p]            = w;
        addr[p*AW +: AW] = ad;
        be[4*p +: 4]     = bb;
        wdata[32*p +: 32] = dd;
    endtask

    // One clock cycle: check DUT against the model, then advance the model past the edge.
    task automatic step();
        bit [1:0]    g;
        bit [1:0]    o;
        int          idx [2];
        logic [31:0] wd;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            wd     = addr[p*AW +: AW] >> 2;
            o[p]   = ERR_EN && (wd >= 32'(TOTAL));
            idx[p] = int'(wd % 32'(TOTAL));
        end
        g = req;
        if (rst) g = 2'b00;
        else if (req == 2'b11 && o == 2'b00 && (idx[0] % NB) == (idx[1] % NB))
            g = (wc == MW) ? 2'b10 : 2'b01;
        check("gnt", 64'(gnt), 64'(g));

        for (int p = 0; p < 2; p++) begin
            rsp_t r;
            bit   ev;
            ev = 1'b0;
            if (!rst) begin
                if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin r = q0.pop_front(); ev = 1'b1; end
                if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin r = q1.pop_front(); ev = 1'b1; end
            end
            check($sformatf("rvalid%0d", p), 64'(rvalid[p]), 64'(ev));
            if (ev) begin
                check($sformatf("err%0d", p), 64'(err[p]), 64'(r.err));
                if (r.rd) check($sformatf("rdata%0d", p), 64'(rdata[32*p +: 32]), 64'(r.data));
            end
        end
        if (rst) begin
            check("rdata_rst", rdata, 64'h0);
            check("err_rst", 64'(err), 64'h0);
        end

        if (rst) begin
            q0.delete();
            q1.delete();
            wc = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    rsp_t r;
                    r.due  = cyc + RL;
                    r.rd   = !we[p];
                    r.err  = o[p];
                    r.data = o[p] ? 32'h0 : mm[idx[p]];
                    if (p == 0) q0.push_back(r);
                    else        q1.push_back(r);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (g[p] && we[p] && !o[p]) begin
                    for (int i = 0; i < 4; i++)
                        if (be[4*p+i]) mm[idx[p]][8*i +: 8] = wdata[32*p + 8*i +: 8];
                end
            end
            if (g[1])                 wc = 0;
            else if (req[1] && wc < MW) wc++;
        end
        last_g = g;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        if ($urandom_range(0, 1) == 0) w = 32'($urandom_range(0, 7));
        else                           w = 32'($urandom_range(0, 2*TOTAL + 3));
        return (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; be = '0; wdata = '0;
        @(posedge clk); #1;

        // Requests during reset must not be granted.
        set_port(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'h4, 4'hf, 32'h1);
        repeat (3) step();
        rst = 1'b0;

        // Fill the whole memory, two different banks per cycle.
        for (int w = 0; w < TOTAL; w += 2) begin
            set_port(0, 1'b1, 1'b1, 32'(w*4),     4'hf, $urandom);
            set_port(1, 1'b1, 1'b1, 32'((w+1)*4), 4'hf, $urandom);
            step();
        end
        idle(RL + 1);

        set_port(0, 1'b1, 1'b1, 32'h10, 4'hf, 32'hDEADBEEF); step();
        set_port(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);        step();
        idle(RL + 1);

        set_port(0, 1'b1, 1'b1, 32'h20, 4'hf, 32'h11223344); step();
        set_port(0, 1'b1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD); step();
        set_port(0, 1'b1, 1'b0, 32'h22, 4'h0, 32'h0);        step();
        set_port(0, 1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF); step();
        set_port(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);        step();
        idle(RL + 1);

        set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'h04, 4'hf, 32'hCAFE0004);
        step();
        idle(RL + 1);

        set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
        repeat (12) step();
        idle(RL + 1);

        set_port(0, 1'b1, 1'b0, 32'(4*TOTAL), 4'h0, 32'h0); step();
        set_port(1, 1'b1, 1'b0, 32'(4*TOTAL + 8), 4'h0, 32'h0);
        set_port(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0); step();
        idle(RL + 1);

        // Build up wait_cnt, then reset right after a grant.
        set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        repeat (2) step();
        req[1] = 1'b0;
        step();
        rst = 1'b1; step();
        rst = 1'b0;
        idle(RL + 2);
        set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        repeat (5) step();
        idle(RL + 1);

        // Random traffic; denied requests are held stable until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !last_g[p])) begin
                    if ($urandom_range(0, 3) != 0)
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
                    else
                        req[p] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle(RL + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
